seq_negate_unit: RTL and testbench

- Multi-cycle ones'/two's-complement unit for the ALU datapath. It completes the bitwise-inversion path with carry-propagated negation and absolute value.
- Processes W bits per cycle, LSB chunk first, carrying the +1 ripple between chunks in a register.
- Start/ready/done handshake, so the control FSM can issue NOT, NEG, ABS or PASS on an N-bit operand and collect the result with flags.

---
 rtl/negu_pkg.sv | 26 ++
 rtl/seq_negate_unit_if.sv | 23 ++
 rtl/neg_chunk.sv | 20 ++
 rtl/seq_negate_unit.sv | 144 ++++++++++++++
 tb/tb_seq_negate_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/negu_pkg.sv
// Shared types and sizing helpers for the sequential negate/abs unit.
package negu_pkg;

  typedef enum logic [1:0] {
    OP_NOT  = 2'b00,
    OP_NEG  = 2'b01,
    OP_ABS  = 2'b10,
    OP_PASS = 2'b11
  } negu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int unsigned nchunk(input int unsigned n, input int unsigned w);
    return n / w;
  endfunction

  // Chunk index needs at least one bit even when the operand is a single chunk.
  function automatic int unsigned idx_width(input int unsigned nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

endpackage

// File: rtl/seq_negate_unit_if.sv
// Start/ready/done handshake plus operand and result bundle for seq_negate_unit.
interface seq_negate_unit_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] A;
  logic         ready;
  logic         done;
  logic [N-1:0] F;
  logic         zero;
  logic         ovf;

  modport master (
    output start, op, A,
    input  ready, done, F, zero, ovf
  );

  modport slave (
    input  start, op, A,
    output ready, done, F, zero, ovf
  );
endinterface

// File: rtl/neg_chunk.sv
// One W-bit slice of the negate datapath: optional bitwise inversion plus carry-in.
module neg_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] chunk_i,
  input  logic         inv_i,
  input  logic         cin_i,
  output logic [W-1:0] r_o,
  output logic         cout_o
);
  logic [W-1:0] chunk_n;
  logic [W-1:0] sel;

  for (genvar i = 0; i < W; i++) begin : g_inv
    assign chunk_n[i] = ~chunk_i[i];
  end

  assign sel = inv_i ? chunk_n : chunk_i;
  assign {cout_o, r_o} = {1'b0, sel} + {{W{1'b0}}, cin_i};
endmodule

// File: rtl/seq_negate_unit.sv
// Multi-cycle NOT/NEG/ABS/PASS unit: W bits per cycle, LSB chunk first, +1 ripple held
// in a carry register between chunks.
module seq_negate_unit
  import negu_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input logic              clk,
  input logic              rst,
  seq_negate_unit_if.slave bus
);
  localparam int unsigned    NCHUNK   = nchunk(N, W);
  localparam int unsigned    IW       = idx_width(NCHUNK);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NCHUNK - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  opnd_q, opnd_d;
  logic [N-1:0]  f_q, f_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          inv_q, inv_d;
  negu_op_t      op_q, op_d;

  logic          accept;
  logic          last_chunk;
  logic [W-1:0]  chunk_in;
  logic [W-1:0]  chunk_r;
  logic          chunk_c;
  logic          ready;
  logic          done;

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign last_chunk = (state_q == S_RUN) && (idx_q == LAST_IDX);
  assign chunk_in   = opnd_q[idx_q*W +: W];

  neg_chunk #(
    .W(W)
  ) u_chunk (
    .chunk_i(chunk_in),
    .inv_i  (inv_q),
    .cin_i  (carry_q),
    .r_o    (chunk_r),
    .cout_o (chunk_c)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      S_IDLE:  ready = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state
  always_comb begin
    opnd_d  = opnd_q;
    f_d     = f_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    op_d    = op_q;
    if (accept) begin
      opnd_d = bus.A;
      f_d    = '0;
      zero_d = 1'b0;
      ovf_d  = 1'b0;
      idx_d  = '0;
      op_d   = negu_op_t'(bus.op);
      unique case (negu_op_t'(bus.op))
        OP_NOT:  begin inv_d = 1'b1;         carry_d = 1'b0;         end
        OP_NEG:  begin inv_d = 1'b1;         carry_d = 1'b1;         end
        OP_ABS:  begin inv_d = bus.A[N-1];   carry_d = bus.A[N-1];   end
        OP_PASS: begin inv_d = 1'b0;         carry_d = 1'b0;         end
        default: begin inv_d = 1'b0;         carry_d = 1'b0;         end
      endcase
    end else if (state_q == S_RUN) begin
      f_d[idx_q*W +: W] = chunk_r;
      carry_d           = chunk_c;
      idx_d             = idx_q + 1'b1;
      if (last_chunk) begin
        // Top-chunk carry-out is dropped; only the MSB reveals the most-negative wrap.
        idx_d  = '0;
        zero_d = (f_d == '0);
        ovf_d  = ((op_q == OP_NEG) || (op_q == OP_ABS)) && opnd_q[N-1] && f_d[N-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q  <= '0;
      f_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      op_q    <= OP_NOT;
    end else begin
      opnd_q  <= opnd_d;
      f_q     <= f_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      op_q    <= op_d;
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.F     = f_q;
  assign bus.zero  = zero_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_seq_negate_unit.sv
// Self-checking bench for seq_negate_unit: directed vector table, random ops vs. an
// arithmetic model, and abort/re-issue sequences.
module tb_seq_negate_unit;
  localparam int unsigned N = 32;
  localparam int unsigned W = 8;
  localparam int          LAT = N / W;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_negate_unit_if #(.N(N)) bus ();

  seq_negate_unit #(
    .N(N),
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] f;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic on the whole word.
  task automatic model(input logic [1:0] op, input logic [31:0] a,
                       output logic [31:0] f, output logic z, output logic o);
    case (op)
      2'b00:   f = ~a;
      2'b01:   f = 32'd0 - a;
      2'b10:   f = a[31] ? (32'd0 - a) : a;
      default: f = a;
    endcase
    z = (f == 32'd0);
    o = (op == 2'b01 || op == 2'b10) && a[31] && f[31];
  endtask

  // Issue one op, wait for done (bounded), check latency, outputs and the one-cycle pulse.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] ef, input logic ez, input logic eo);
    int lat;
    logic [31:0] f_seen;
    @(negedge clk);
    check({name, ".ready_before"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.A     = $urandom;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'(LAT));
    check({name, ".F"}, bus.F, ef);
    check({name, ".zero_ovf"}, {30'd0, bus.zero, bus.ovf}, {30'd0, ez, eo});
    f_seen = bus.F;
    @(negedge clk);
    check({name, ".post_ready_done"}, {30'd0, bus.ready, bus.done}, 32'd2);
    check({name, ".F_hold"}, bus.F, f_seen);
  endtask

  initial begin
    logic [31:0] rf;
    logic        rz;
    logic        ro;
    logic [1:0]  rop;
    logic [31:0] ra;
    int          dones;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;

    vecs[0] = '{op: 2'b01, a: 32'h0000_0001, f: 32'hFFFF_FFFF, z: 1'b0, o: 1'b0};
    vecs[1] = '{op: 2'b01, a: 32'h0000_0000, f: 32'h0000_0000, z: 1'b1, o: 1'b0};
    vecs[2] = '{op: 2'b01, a: 32'h8000_0000, f: 32'h8000_0000, z: 1'b0, o: 1'b1};
    vecs[3] = '{op: 2'b10, a: 32'hFFFF_FF00, f: 32'h0000_0100, z: 1'b0, o: 1'b0};
    vecs[4] = '{op: 2'b10, a: 32'h1234_5678, f: 32'h1234_5678, z: 1'b0, o: 1'b0};
    vecs[5] = '{op: 2'b00, a: 32'h0F0F_00FF, f: 32'hF0F0_FF00, z: 1'b0, o: 1'b0};
    vecs[6] = '{op: 2'b11, a: 32'hDEAD_BEEF, f: 32'hDEAD_BEEF, z: 1'b0, o: 1'b0};
    vecs[7] = '{op: 2'b10, a: 32'h8000_0000, f: 32'h8000_0000, z: 1'b0, o: 1'b1};
    vecs[8] = '{op: 2'b00, a: 32'hFFFF_FFFF, f: 32'h0000_0000, z: 1'b1, o: 1'b0};
    vecs[9] = '{op: 2'b01, a: 32'hFFFF_FFFF, f: 32'h0000_0001, z: 1'b0, o: 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check("reset.outputs", {bus.F[27:0], bus.ready, bus.done, bus.zero, bus.ovf},
          {28'd0, 4'b1000});
    check("reset.F", bus.F, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("idle.no_done", 32'(dones), 32'd0);
    check("idle.ready", 32'(bus.ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].f, vecs[i].z, vecs[i].o);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      if (i % 8 == 0) ra = 32'h8000_0000;
      if (i % 8 == 1) ra = 32'h0;
      model(rop, ra, rf, rz, ro);
      run_op($sformatf("rand%0d", i), rop, ra, rf, rz, ro);
    end

    // Start during RUN is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.A     = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort.busy_ready", 32'(bus.ready), 32'd0);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.A     = 32'h0000_0077;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    while (!bus.done && dones < 20) begin
      @(negedge clk);
      dones++;
    end
    check("ignore.F", bus.F, 32'hFFFF_FFFB);
    @(negedge clk);

    // Reset mid-RUN: immediate idle, no done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.A     = 32'h9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.outputs", {28'd0, bus.ready, bus.done, bus.zero, bus.ovf}, 32'h8);
    check("midrst.F", bus.F, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst.no_done", 32'(dones), 32'd0);

    run_op("reissue", 2'b01, 32'h2, 32'hFFFF_FFFE, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end
endmodule
